conv_stream_feeder: RTL
=======================

// Module: conv_stream_feeder
// PURPOSE
//  Host-side sequencer that drives conv_controller's command strobes (sample_load_en, new_row,
//  coeff_load_en) and paces them by its modwait. Walks a WxH image as 3-row windows, column by
//  column, and publishes col/row indices so the sample source presents matching data.
//  Counts convolve_en pulses and flags completion/mismatch. Sits between host regs and controller.
// PARAMETERS
//  DIM_W  8  width of image dimension, index and counter fields (max dimension 2^DIM_W-1)
// PORTS
//  clk            in   1        system clock
//  n_rst          in   1        asynchronous active-low reset
//  start          in   1        pulse: begin image pass using img_width/img_height
//  load_coeffs    in   1        pulse: issue one coefficient-load command
//  img_width      in   DIM_W    columns W, sampled on accepted start
//  img_height     in   DIM_W    rows H, sampled on accepted start
//  modwait        in   1        controller busy; no strobe may be issued while high
//  convolve_en    in   1        controller convolve pulse (one output pixel)
//  sample_load_en out  1        strobe: load next column sample
//  new_row        out  1        strobe: start next window row (alone) / end image (with sample_load_en)
//  coeff_load_en  out  1        strobe: load 3 coefficients
//  col_idx        out  DIM_W    column loaded by current strobe
//  row_idx        out  DIM_W    top row of current 3-row window
//  busy           out  1        high whenever not IDLE
//  done           out  1        1-cycle pulse at image end
//  err            out  1        sticky: bad dimensions or convolve count mismatch; cleared by accepted start
//  conv_count     out  2*DIM_W  convolve_en pulses since last accepted start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-operation abandons the image, no done.
//  Strobes are Moore outputs of ISSUE states, exactly 1 cycle high; indices valid in that cycle.
//  Pacing: ISSUE -> GAP (1 cycle, modwait not yet visible) -> WAITMOD (hold while modwait=1)
//   -> next ISSUE/DONE the cycle after modwait=0 seen. Minimum strobe spacing 3 cycles.
//  States: IDLE, COEFF, SAMP, ROW, END, GAP, WAITMOD, DONE.
//  IDLE: load_coeffs -> COEFF (priority over simultaneous start). start -> if W<3 or H<3: set err,
//   stay IDLE; else latch W,H, clear conv_count/err, col=0,row=0 -> SAMP. Both ignored when busy.
//  COEFF: coeff_load_en=1 -> GAP -> WAITMOD (modwait high 3 cycles) -> IDLE.
//  SAMP: sample_load_en=1 at col_idx; then col++ unless col=W-1.
//  After WAITMOD with col=W-1: if row<H-3 -> ROW (new_row=1 only, col=0, row++; loads col 0 of
//   next window); else -> END.
//  After WAITMOD with col<W-1: -> SAMP.
//  ROW followed by SAMP for cols 1..W-1; every window pass gives W-2 convolve_en pulses.
//  END: new_row=1 AND sample_load_en=1 same cycle; controller returns to idle, no modwait;
//   -> DONE (done=1, err|=conv_count!=(W-2)*(H-2)) -> IDLE.
//  conv_count: +1 per convolve_en cycle while busy; width 2*DIM_W, no wrap possible for legal dims.
//  coeff_load_en never issued during an image; load_coeffs while busy dropped (no queue).
// STRUCTURE
//  conv_pkg: feeder_state_t enum, DIM_W default, MIN_DIM=3 constant.
//  Sub-module: flex_counter (NUM_CNT_BITS=DIM_W) for col_idx, rollover at W-1, clear on start/ROW.
//  Row counter, conv_count and dims registered in top; one state register + next-state comb.
// TESTING (bench includes behavioural conv_controller model driving modwait/convolve_en)
//  load_coeffs pulse -> one coeff_load_en cycle, busy 5 cycles, IDLE after modwait drops; no sample strobes.
//  start W=3,H=3 -> SAMP c0,c1,c2 then END (both strobes high 1 cycle); conv_count=1, done, err=0.
//  start W=5,H=4 -> c0..c4, ROW(row_idx=1,c0), c1..c4, END; conv_count=6, done, err=0.
//  model stretches modwait 10 cycles after c1 -> no strobe while modwait=1; c2 exactly 1 cycle after release.
//  start W=2,H=9 -> err=1, busy stays 0; start during image and load_coeffs during image ignored.
//  n_rst low mid-row (W=8,H=8, col 4) -> all outputs 0 immediately; fresh start runs cleanly.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and dimension constants for the conv stream feeder
package conv_pkg;
  localparam int DEF_DIM_W = 8;
  localparam int MIN_DIM = 3;
  typedef enum logic [2:0] {IDLE, COEFF, SAMP, ROW, END, GAP, WAITMOD, DONE} feeder_state_t;
endpackage

// File: rtl/flex_counter.sv
// flex_counter: clearable up-counter with programmable rollover value and terminal flag
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    i_clear,
  input  logic                    i_count_enable,
  input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
  output logic [NUM_CNT_BITS-1:0] o_count,
  output logic                    o_rollover_flag
);
  localparam logic [NUM_CNT_BITS-1:0] L_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
  logic [NUM_CNT_BITS-1:0] r_cnt;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_count_enable) r_cnt <= o_rollover_flag ? '0 : r_cnt + L_ONE;
  assign o_count = r_cnt;
  assign o_rollover_flag = r_cnt == i_rollover_val;
endmodule

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: walks a WxH image as 3-row windows, issuing modwait-paced controller strobes
module conv_stream_feeder import conv_pkg::*; #(
  parameter int DIM_W = DEF_DIM_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               load_coeffs,
  input  logic [DIM_W-1:0]   img_width,
  input  logic [DIM_W-1:0]   img_height,
  input  logic               modwait,
  input  logic               convolve_en,
  output logic               sample_load_en,
  output logic               new_row,
  output logic               coeff_load_en,
  output logic [DIM_W-1:0]   col_idx,
  output logic [DIM_W-1:0]   row_idx,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*DIM_W-1:0] conv_count
);
  localparam logic [DIM_W-1:0] L_MIN = DIM_W'(MIN_DIM);
  localparam logic [DIM_W-1:0] L_ONE = DIM_W'(1);
  localparam logic [DIM_W-1:0] L_TWO = DIM_W'(2);
  localparam logic [2*DIM_W-1:0] L_CONV_ONE = (2*DIM_W)'(1);
  feeder_state_t r_state, w_next;
  logic [DIM_W-1:0] r_w, r_h, r_row, w_col;
  logic [2*DIM_W-1:0] r_conv, w_expect;
  logic r_err, r_img, w_col_last, w_bad, w_req, w_accept, w_more_rows, w_col_clr, w_col_en;
  assign w_bad = (img_width < L_MIN) || (img_height < L_MIN);
  assign w_req = (r_state == IDLE) && start && !load_coeffs;
  assign w_accept = w_req && !w_bad;
  assign w_more_rows = r_row < (r_h - L_MIN);
  assign w_expect = {{DIM_W{1'b0}}, r_w - L_TWO} * {{DIM_W{1'b0}}, r_h - L_TWO};
  // WAITMOD is shared by coefficient and image passes; r_img picks the return path
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:              w_next = load_coeffs ? COEFF : w_accept ? SAMP : IDLE;
      COEFF, SAMP, ROW:  w_next = GAP;
      GAP:               w_next = WAITMOD;
      WAITMOD:           w_next = modwait ? WAITMOD : !r_img ? IDLE : !w_col_last ? SAMP
                                  : w_more_rows ? ROW : END;
      END:               w_next = DONE;
      DONE:              w_next = IDLE;
      default:           w_next = IDLE;
    endcase
  end
  assign w_col_clr = w_accept || (r_state == WAITMOD && w_next == ROW);
  assign w_col_en = r_state == WAITMOD && w_next == SAMP;
  flex_counter #(.NUM_CNT_BITS(DIM_W)) u_col (
    .clk(clk),
    .n_rst(n_rst),
    .i_clear(w_col_clr),
    .i_count_enable(w_col_en),
    .i_rollover_val(r_w - L_ONE),
    .o_count(w_col),
    .o_rollover_flag(w_col_last)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_state <= IDLE;
      r_w <= '0;
      r_h <= '0;
      r_row <= '0;
      r_conv <= '0;
      r_err <= 1'b0;
      r_img <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_w <= img_width;
        r_h <= img_height;
        r_row <= '0;
        r_conv <= '0;
        r_err <= 1'b0;
        r_img <= 1'b1;
      end else begin
        if (w_req && w_bad) r_err <= 1'b1;
        if (r_state == WAITMOD && w_next == ROW) r_row <= r_row + L_ONE;
        if (r_state != IDLE && convolve_en) r_conv <= r_conv + L_CONV_ONE;
        if (r_state == DONE) begin
          r_img <= 1'b0;
          if (r_conv != w_expect) r_err <= 1'b1;
        end
      end
    end
  assign sample_load_en = r_state inside {SAMP, END};
  assign new_row = r_state inside {ROW, END};
  assign coeff_load_en = r_state == COEFF;
  assign col_idx = w_col;
  assign row_idx = r_row;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign err = r_err;
  assign conv_count = r_conv;
endmodule
